// File: rtl/extmem_bridge_pkg.sv
// Shared types and default sizing for the external-memory bridge.
// The state enum is used by the top-level sequencer.
package extmem_bridge_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 16;
    localparam int WF_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        R_DRAIN = 2'd1,
        R_REQ   = 2'd2,
        R_WAIT  = 2'd3
    } BridgeStates;

endpackage

// File: rtl/bridge_wfifo.sv
// Posted-write FIFO holding {addr, data} pairs for the memory-side drain.
// Depth must be a power of two so the pointers wrap on their own.
module bridge_wfifo
    import extmem_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = WF_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign {head_addr, head_data} = mem[rd_ptr];

    // Storage needs no reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {push_addr, push_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/extmem_bridge.sv
// Bridges controller memory requests to the off-chip port: writes are posted
// through a FIFO, reads wait for every earlier write to drain first.
//
// state   | meaning
// IDLE    | accepting requests, draining posted writes
// R_DRAIN | read latched, still draining writes ahead of it
// R_REQ   | read request on the memory port, waiting for grant
// R_WAIT  | read granted, waiting for m_rvalid
module extmem_bridge
    import extmem_bridge_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WF_DEPTH = WF_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_wr_addr,
    input  logic [DATA_W-1:0] c_wr_data,
    input  logic              c_re,
    input  logic [ADDR_W-1:0] c_rd_addr,
    output logic [DATA_W-1:0] c_rd_data,
    output logic              c_rd_valid,
    output logic              c_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_gnt,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = $clog2(WF_DEPTH+1);

    BridgeStates       state;
    BridgeStates       state_nxt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  wf_count;
    logic              wf_full;
    logic              wf_empty;
    logic              wf_push;
    logic              wf_pop;
    logic              rd_accept;
    logic              rd_return;
    logic              drain_phase;

    // Stall depends on registers only, so the controller sees it early in the cycle.
    assign c_stall     = wf_full | (state != IDLE);
    assign wf_push     = c_we & ~c_stall;
    assign rd_accept   = c_re & ~c_stall;
    assign drain_phase = ((state == IDLE) || (state == R_DRAIN)) && !wf_empty;
    assign wf_pop      = drain_phase & m_gnt;
    assign rd_return   = (state == R_WAIT) & m_rvalid;

    bridge_wfifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WF_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wf_push),
        .push_addr (c_wr_addr),
        .push_data (c_wr_data),
        .pop       (wf_pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .count     (wf_count),
        .full      (wf_full),
        .empty     (wf_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_accept)         state_nxt = R_DRAIN;
            R_DRAIN: if (wf_count == '0)    state_nxt = R_REQ;
            R_REQ:   if (m_gnt)             state_nxt = R_WAIT;
            R_WAIT:  if (m_rvalid)          state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Memory-side mux: posted writes first, then the single outstanding read.
    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (drain_phase) begin
            m_req   = 1'b1;
            m_we    = 1'b1;
            m_addr  = head_addr;
            m_wdata = head_data;
        end else if (state == R_REQ) begin
            m_req   = 1'b1;
            m_addr  = rd_addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_rd_valid <= 1'b0;
            c_rd_data  <= '0;
            rd_addr_q  <= '0;
        end else begin
            c_rd_valid <= rd_return;
            if (rd_return) begin
                c_rd_data <= m_rdata;
            end
            if (rd_accept) begin
                rd_addr_q <= c_rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_extmem_bridge.sv
// Bench for extmem_bridge: a transaction-level model (write queue, memory
// image, one pending read) is compared with the DUT every cycle.
module tb_extmem_bridge;
    import extmem_bridge_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          c_we = 1'b0, c_re = 1'b0;
    logic [AW-1:0] c_wr_addr = '0, c_rd_addr = '0;
    logic [DW-1:0] c_wr_data = '0;
    logic [DW-1:0] c_rd_data;
    logic          c_rd_valid, c_stall, m_req, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_gnt = 1'b0, m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    always #5 clk = ~clk;

    extmem_bridge #(.ADDR_W(AW), .DATA_W(DW), .WF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .c_we(c_we), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
        .c_re(c_re), .c_rd_addr(c_rd_addr),
        .c_rd_data(c_rd_data), .c_rd_valid(c_rd_valid), .c_stall(c_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    // transaction-level model
    wr_t           wq[$];
    logic [DW-1:0] mdl_mem [logic [AW-1:0]];
    bit            rd_pend, rd_granted, prev_empty_pend, rv_due, rd_issue_now;
    bit            wr_acc, rd_acc;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] last_rd;
    int            n_cmp = 0, n_mis = 0, rv_pulses = 0;

    // memory device
    logic [DW-1:0] dev_mem [logic [AW-1:0]];
    int            gnt_mode = 0;      // 0 tied high, 1 zero, 2 random, 3 after 3 cycles
    int            rv_lat_max = 1;
    bit            rv_en = 1, stray_en = 0, force_stray = 0;
    int            req_age = 0, dev_cnt = 0;
    bit            dev_busy = 0;
    logic [AW-1:0] dev_addr;
    logic          snap_req, snap_we;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mdl_rd(input logic [AW-1:0] a);
        return mdl_mem.exists(a) ? mdl_mem[a] : '0;
    endfunction

    task automatic model_check();
        bit exp_stall;
        exp_stall    = (wq.size() == DEPTH) || rd_pend;
        rd_issue_now = rd_pend && !rd_granted && (wq.size() == 0) && prev_empty_pend;
        chk("c_stall", c_stall, exp_stall);
        if (wq.size() > 0) begin
            chk("m_req_wr", m_req, 1);
            chk("m_we_wr", m_we, 1);
            chk("m_addr_wr", m_addr, wq[0].a);
            chk("m_wdata_wr", m_wdata, wq[0].d);
        end else if (rd_issue_now) begin
            chk("m_req_rd", m_req, 1);
            chk("m_we_rd", m_we, 0);
            chk("m_addr_rd", m_addr, rd_addr);
        end else begin
            chk("m_req_idle", m_req, 0);
        end
        chk("c_rd_valid", c_rd_valid, rv_due);
        chk("c_rd_data", c_rd_data, last_rd);
        if (c_rd_valid) rv_pulses++;
        snap_req   = m_req;
        snap_we    = m_we;
        snap_addr  = m_addr;
        snap_wdata = m_wdata;
    endtask

    task automatic drive_dev();
        case (gnt_mode)
            0:       m_gnt = 1'b1;
            1:       m_gnt = 1'b0;
            2:       m_gnt = ($urandom_range(0, 2) != 0);
            default: m_gnt = snap_req && (req_age >= 3);
        endcase
        m_rvalid = 1'b0;
        m_rdata  = DW'($urandom);
        if (dev_busy && dev_cnt == 1 && rv_en) begin
            m_rvalid = 1'b1;
            m_rdata  = dev_mem.exists(dev_addr) ? dev_mem[dev_addr] : '0;
        end else if (!dev_busy && (force_stray || (stray_en && $urandom_range(0, 3) == 0))) begin
            m_rvalid = 1'b1;
            if (force_stray) m_rdata = 16'hDEAD;
        end
    endtask

    // One clock: apply device response, advance model and device at the edge, check.
    task automatic tick();
        bit stall, q_empty_now, pend_old;
        wr_t e;
        drive_dev();
        @(posedge clk);
        stall       = (wq.size() == DEPTH) || rd_pend;
        q_empty_now = (wq.size() == 0);
        pend_old    = rd_pend;
        wr_acc      = c_we && !stall;
        rd_acc      = c_re && !stall;
        rv_due      = 0;
        if (dev_busy) begin
            if (m_rvalid) dev_busy = 0;
            else if (dev_cnt > 1) dev_cnt--;
        end
        if (snap_req && m_gnt) begin
            if (snap_we) dev_mem[snap_addr] = snap_wdata;
            else begin
                dev_busy = 1;
                dev_cnt  = $urandom_range(1, rv_lat_max);
                dev_addr = snap_addr;
            end
        end
        if (snap_req && !m_gnt) req_age++;
        else req_age = 0;
        if (!q_empty_now && m_gnt) begin
            e = wq.pop_front();
            mdl_mem[e.a] = e.d;
        end
        if (rd_issue_now && m_gnt) rd_granted = 1;
        else if (rd_granted && m_rvalid) begin
            rv_due     = 1;
            last_rd    = mdl_rd(rd_addr);
            rd_pend    = 0;
            rd_granted = 0;
        end
        prev_empty_pend = pend_old && q_empty_now;
        if (wr_acc) wq.push_back({c_wr_addr, c_wr_data});
        if (rd_acc) begin
            rd_pend    = 1;
            rd_addr    = c_rd_addr;
            rd_granted = 0;
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b0;
        wq.delete();
        rd_pend = 0; rd_granted = 0; prev_empty_pend = 0; rv_due = 0;
        last_rd = '0; dev_busy = 0; req_age = 0;
        for (int i = 0; i < n; i++) begin
            c_we = 1'($urandom); c_re = 1'($urandom);
            c_wr_addr = $urandom; c_rd_addr = $urandom; c_wr_data = DW'($urandom);
            m_gnt = 1'($urandom); m_rvalid = 1'($urandom); m_rdata = DW'($urandom);
            #1;
            chk("rst_c_stall", c_stall, 0);
            chk("rst_c_rd_valid", c_rd_valid, 0);
            chk("rst_c_rd_data", c_rd_data, 0);
            chk("rst_m_req", m_req, 0);
            chk("rst_m_we", m_we, 0);
            chk("rst_m_addr", m_addr, 0);
            chk("rst_m_wdata", m_wdata, 0);
            @(negedge clk);
        end
        c_we = 0; c_re = 0; m_gnt = 0; m_rvalid = 0;
        rst = 1'b1;
        model_check();
    endtask

    task automatic ctl_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        c_we = 1; c_wr_addr = a; c_wr_data = d;
        do begin tick(); n++; end while (!wr_acc && n < 200);
        if (!wr_acc) chk("write_accept_timeout", 0, 1);
        c_we = 0;
    endtask

    task automatic ctl_read(input logic [AW-1:0] a);
        int n = 0;
        c_re = 1; c_rd_addr = a;
        do begin tick(); n++; end while (!rd_acc && n < 200);
        if (!rd_acc) chk("read_accept_timeout", 0, 1);
        c_re = 0;
    endtask

    task automatic wait_read_done();
        int n = 0;
        while (!rv_due && n < 300) begin tick(); n++; end
        if (!rv_due) chk("read_return_timeout", 0, 1);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n, p0;
        @(negedge clk);
        apply_reset(3);

        // single posted write, grant tied high: one request cycle
        gnt_mode = 0;
        c_we = 1; c_wr_addr = 32'h100; c_wr_data = 16'hBEEF;
        tick();
        c_we = 0;
        chk("sw_m_req", m_req, 1);
        chk("sw_m_we", m_we, 1);
        chk("sw_m_addr", m_addr, 32'h100);
        chk("sw_m_wdata", m_wdata, 16'hBEEF);
        tick();
        chk("sw_m_req_done", m_req, 0);

        // fill the FIFO with grant withheld
        gnt_mode = 1;
        for (int i = 0; i < 8; i++) begin
            c_we = 1; c_wr_addr = 32'h200 + i; c_wr_data = 16'hA000 + 16'(i);
            tick();
        end
        chk("full_stall", c_stall, 1);
        c_wr_addr = 32'h208; c_wr_data = 16'hA008;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ninth_held_stall", c_stall, 1);
        end
        gnt_mode = 0;
        n = 0;
        do begin tick(); n++; end while (!wr_acc && n < 50);
        c_we = 0;
        chk("ninth_accept_ticks", n, 2);
        idle_ticks(10);

        // RAW ordering with grant delayed 3 cycles per request
        gnt_mode = 3; rv_lat_max = 2;
        for (int i = 0; i < 4; i++) ctl_write(32'h10 + i, 16'h1000 + 16'(i));
        ctl_read(32'h12);
        p0 = rv_pulses;
        wait_read_done();
        chk("raw_rd_data", c_rd_data, 16'h1002);
        idle_ticks(4);
        chk("raw_single_pulse", rv_pulses - p0, 1);

        // same-cycle write and read to one address
        gnt_mode = 2;
        c_we = 1; c_wr_addr = 32'h20; c_wr_data = 16'h5A5A;
        c_re = 1; c_rd_addr = 32'h20;
        tick();
        c_we = 0; c_re = 0;
        chk("wr_rd_both_accepted", {wr_acc, rd_acc}, 2'b11);
        wait_read_done();
        chk("wr_rd_data", c_rd_data, 16'h5A5A);
        idle_ticks(3);

        // reset while waiting for read data
        gnt_mode = 0; rv_en = 0;
        ctl_read(32'h10);
        n = 0;
        while (!rd_granted && n < 50) begin tick(); n++; end
        tick(); tick();
        p0 = rv_pulses;
        apply_reset(1);
        rv_en = 1;
        idle_ticks(6);
        chk("rst_no_rd_valid", rv_pulses - p0, 0);
        ctl_read(32'h12);
        wait_read_done();
        chk("post_rst_rd_data", c_rd_data, 16'h1002);
        idle_ticks(2);

        // stray m_rvalid while idle
        force_stray = 1;
        p0 = rv_pulses;
        idle_ticks(3);
        force_stray = 0;
        chk("stray_no_valid", rv_pulses - p0, 0);
        chk("stray_data_kept", c_rd_data, 16'h1002);

        // randomized traffic with random grants, latency and stray rvalid
        gnt_mode = 2; rv_lat_max = 4; stray_en = 1;
        wr_acc = 0; rd_acc = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!(c_we && !wr_acc)) begin
                c_we = ($urandom_range(0, 2) == 0);
                c_wr_addr = 32'h40 + 32'($urandom_range(0, 7));
                c_wr_data = DW'($urandom);
            end
            if (!(c_re && !rd_acc)) begin
                c_re = ($urandom_range(0, 5) == 0);
                c_rd_addr = 32'h40 + 32'($urandom_range(0, 7));
            end
            tick();
            if (wr_acc) c_we = 0;
            if (rd_acc) c_re = 0;
        end
        c_we = 0; c_re = 0; stray_en = 0; gnt_mode = 0;
        idle_ticks(20);
        chk("final_drained_stall", c_stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
